sr_ff_drv: RTL and testbench
============================

Name: sr_ff_drv

Overview:
- Initiator-side driver for the team's clocked SR flip-flop: accepts "make Q = v" requests over a valid/ready handshake.
- Converts each request into a SET or RESET pulse of programmable length.
- Watches the flip-flop's Q/QN feedback for confirmation, then reports DONE or ERR (timeout).
- Sits between control logic and any SR-style storage element so callers never drive SET/RESET directly.

Parameters:
- PULSE_LEN, 1, number of cycles SET or RESET is held high per request (>=1)
- TIMEOUT, 8, max number of feedback samples taken in WAIT before declaring error (>=1)
- CNT_W, 4, counter width; must hold max(PULSE_LEN, TIMEOUT)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RSTN  in  1  synchronous reset, active low
- REQ_VALID  in  1  request present
- REQ_VAL  in  1  requested Q value (1 = set, 0 = reset)
- REQ_READY  out  1  driver can accept a request
- SET  out  1  set pulse to flip-flop
- RESET  out  1  reset pulse to flip-flop
- Q_FB  in  1  flip-flop Q feedback
- QN_FB  in  1  flip-flop QN feedback
- BUSY  out  1  request in progress (state != IDLE)
- DONE  out  1  one-cycle pulse: request confirmed
- ERR  out  1  one-cycle pulse: request timed out

Behaviour:
- Reset (RSTN=0 at an edge) is synchronous. It forces state=IDLE, SET=0, RESET=0, DONE=0, ERR=0, BUSY=0, and clears both counters and the latched target. It applies identically mid-pulse or mid-wait.
  - SET/RESET drop in the cycle after that edge.
  - No DONE/ERR is produced for the aborted request.
  - REQ_VALID is ignored at any edge where RSTN=0.
- All outputs are registered except REQ_READY = (state==IDLE) and BUSY = (state!=IDLE).
- Handshake: a transfer occurs at an edge where REQ_VALID=1, REQ_READY=1 and RSTN=1. REQ_VAL is latched as target at that edge.
- "Confirmed" means Q_FB==target and QN_FB==~target. Q_FB==QN_FB (invalid) never counts as confirmed.
- States:
  - IDLE: REQ_READY=1. On transfer:
    - If feedback is already confirmed for REQ_VAL at the transfer edge: stay IDLE, issue no pulse, DONE=1 in the next cycle.
    - Otherwise: go to PULSE, pulse counter=0.
  - PULSE: SET=target, RESET=~target, held for exactly PULSE_LEN cycles. SET and RESET are never both 1. After the PULSE_LEN-th cycle, go to WAIT with wait counter=0. Feedback is ignored in PULSE.
  - WAIT: SET=RESET=0. Feedback is sampled at each edge.
    - Confirmed: go to IDLE with DONE=1 in the next cycle.
    - Else, if this was the TIMEOUT-th sample: go to IDLE with ERR=1 in the next cycle.
    - Else: increment the wait counter.
- DONE/ERR are high exactly one cycle, coinciding with the first IDLE cycle. They are never both high.
- A new request may be accepted in the same cycle DONE/ERR is high (back-to-back).
- Latency with a responsive registered flip-flop: transfer at edge 0 -> SET/RESET high in cycles 1..PULSE_LEN -> first WAIT sample at edge PULSE_LEN+1 -> DONE in cycle PULSE_LEN+2.
- Timeout latency: ERR in cycle PULSE_LEN+TIMEOUT+1 after the transfer edge.
- REQ_VALID/REQ_VAL changes while BUSY have no effect. The target is fixed for the whole request.
- Counters saturate/reset per state entry and never wrap within a request.

Test Plan:
- Reset then idle: hold RSTN=0 for 2 cycles, release -> SET=RESET=DONE=ERR=BUSY=0, REQ_READY=1.
- Set request with a real flip-flop attached, PULSE_LEN=1, Q=0 initially: REQ_VALID=1, REQ_VAL=1 at edge 0 -> SET=1 in cycle 1 only, RESET=0 throughout, Q=1 from cycle 2, DONE=1 in cycle 3, BUSY=1 in cycles 1-2.
- Already satisfied: Q_FB=1, QN_FB=0, request REQ_VAL=1 -> no SET/RESET pulse, DONE=1 next cycle, REQ_READY stays 1.
- Timeout: PULSE_LEN=2, TIMEOUT=3, feedback stuck Q_FB=0, QN_FB=1, request REQ_VAL=1 -> SET high cycles 1-2, ERR=1 in cycle 6 only, DONE never asserted.
- Invalid feedback: Q_FB=QN_FB=1 during WAIT for a set request -> not confirmed, ERR after TIMEOUT samples.
- Reset mid-pulse: PULSE_LEN=4, assert RSTN=0 at edge 2 -> SET=0 from cycle 3, no DONE/ERR, REQ_READY=1 after release; a following reset request (REQ_VAL=0) drives RESET for 4 cycles and DONE.

Source files
------------

// File: rtl/sr_ff_drv.sv
// Request-driven SET/RESET pulse driver for an SR flip-flop, confirming the new state via Q/QN feedback.
// DONE at PULSE_LEN+2 cycles after transfer, ERR at PULSE_LEN+TIMEOUT+1; REQ_READY stays low while a request is in flight.
module sr_ff_drv #(
  parameter int PULSE_LEN = 1,
  parameter int TIMEOUT   = 8,
  parameter int CNT_W     = 4
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic REQ_VALID,
  input  logic REQ_VAL,
  output logic REQ_READY,
  output logic SET,
  output logic RESET,
  input  logic Q_FB,
  input  logic QN_FB,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT} state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             target, target_nxt;
  logic             set_nxt, rst_nxt, done_nxt, err_nxt;
  logic             req_match, tgt_match;

  // Q==QN is never a valid confirmation, so both rails must agree with the target
  assign req_match = (Q_FB == REQ_VAL) && (QN_FB == !REQ_VAL);
  assign tgt_match = (Q_FB == target)  && (QN_FB == !target);

  assign REQ_READY = (state == ST_IDLE);
  assign BUSY      = (state != ST_IDLE);

  always_comb begin
    state_nxt     = state;
    pulse_cnt_nxt = pulse_cnt;
    wait_cnt_nxt  = wait_cnt;
    target_nxt    = target;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (REQ_VALID) begin
          target_nxt = REQ_VAL;
          if (req_match) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt     = ST_PULSE;
            pulse_cnt_nxt = '0;
          end
        end
      end
      ST_PULSE: begin
        if (pulse_cnt == PULSE_LAST) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = '0;
        end else begin
          pulse_cnt_nxt = pulse_cnt + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (tgt_match) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Pulse outputs are registered from the next state so they line up with PULSE occupancy
    set_nxt = (state_nxt == ST_PULSE) &&  target_nxt;
    rst_nxt = (state_nxt == ST_PULSE) && !target_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      pulse_cnt <= '0;
      wait_cnt  <= '0;
      target    <= 1'b0;
      SET       <= 1'b0;
      RESET     <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      target    <= target_nxt;
      SET       <= set_nxt;
      RESET     <= rst_nxt;
      DONE      <= done_nxt;
      ERR       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sr_ff_drv.sv
// Scoreboard bench for sr_ff_drv driving a behavioural SR flip-flop with selectable feedback faults.
module tb_sr_ff_drv;

  localparam int PL = 2;
  localparam int TO = 3;

  logic clk;
  logic rstn, req_valid, req_val, q_fb, qn_fb;
  logic req_ready, set_o, reset_o, busy, done, err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sr_ff_drv #(.PULSE_LEN(PL), .TIMEOUT(TO), .CNT_W(4)) dut (
    .CLK(clk), .RSTN(rstn), .REQ_VALID(req_valid), .REQ_VAL(req_val),
    .REQ_READY(req_ready), .SET(set_o), .RESET(reset_o),
    .Q_FB(q_fb), .QN_FB(qn_fb), .BUSY(busy), .DONE(done), .ERR(err)
  );

  // fb_mode: 0 = real flip-flop, 1 = stuck Q=0/QN=1, 2 = invalid Q=QN=1
  logic ff_q = 1'b0;
  int   fb_mode = 0;
  always @(posedge clk) begin
    if (set_o === 1'b1) ff_q <= 1'b1;
    else if (reset_o === 1'b1) ff_q <= 1'b0;
  end
  assign q_fb  = (fb_mode == 0) ? ff_q  : (fb_mode == 2);
  assign qn_fb = (fb_mode == 0) ? !ff_q : 1'b1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  typedef struct {
    bit is_err;
    int cyc;
  } res_t;
  res_t       exp_q[$];
  logic [1:0] exp_pulse[int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [1:0] ep;
    res_t r;
    if (mon_en) begin
      ep = exp_pulse.exists(cyc) ? exp_pulse[cyc] : 2'b00;
      check($sformatf("set_reset_c%0d", cyc), 32'({set_o, reset_o}), 32'(ep));
      if (done !== 1'b0 || err !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'({done, err}), 32'd0);
        end else begin
          r = exp_q.pop_front();
          check("result_cycle", 32'(cyc), 32'(r.cyc));
          check("result_kind", 32'({done, err}), r.is_err ? 32'd1 : 32'd2);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // kind: 0 = pulse then DONE, 1 = already satisfied DONE, 2 = pulse then ERR
  task automatic issue(input logic v, input int kind, output int res_cyc);
    int   e;
    res_t r;
    e = cyc;
    check("ready_at_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_val   = v;
    r.is_err  = (kind == 2);
    if (kind == 1) begin
      r.cyc = e + 1;
    end else begin
      for (int k = 1; k <= PL; k++) exp_pulse[e + k] = v ? 2'b10 : 2'b01;
      r.cyc = (kind == 2) ? e + PL + TO + 1 : e + PL + 2;
    end
    exp_q.push_back(r);
    res_cyc = r.cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin : stim
    int rc;
    int e;
    rstn = 1'b0;
    req_valid = 1'b1;
    req_val = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    req_valid = 1'b0;
    mon_en = 1'b1;
    check("rst_set", 32'(set_o), 32'd0);
    check("rst_reset", 32'(reset_o), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // set with real flip-flop, Q=0
    issue(1'b1, 0, rc);
    check("busy_in_pulse", 32'(busy), 32'd1);
    check("ready_in_pulse", 32'(req_ready), 32'd0);
    wait_until(rc);
    // back-to-back reset request in the DONE cycle; stray request while busy is ignored
    issue(1'b0, 0, rc);
    req_valid = 1'b1;
    req_val = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_until(rc + 1);

    // already satisfied (Q=0, request 0)
    issue(1'b0, 1, rc);
    check("sat_ready", 32'(req_ready), 32'd1);
    check("sat_busy", 32'(busy), 32'd0);
    wait_until(rc + 1);

    // feedback stuck low
    fb_mode = 1;
    issue(1'b1, 2, rc);
    wait_until(rc + 1);
    check("ready_after_err", 32'(req_ready), 32'd1);

    // invalid feedback Q=QN=1 is never confirmation
    fb_mode = 2;
    issue(1'b1, 2, rc);
    wait_until(rc + 1);
    fb_mode = 0;

    // bring Q back to 0 (flip-flop holds 1 after the faulted set pulses)
    issue(1'b0, 0, rc);
    wait_until(rc + 1);

    // reset mid-pulse: only the first SET cycle appears, no result
    e = cyc;
    req_valid = 1'b1;
    req_val = 1'b1;
    exp_pulse[e + 1] = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    // flip-flop saw the one SET cycle, so a reset request needs a RESET pulse
    issue(1'b0, 0, rc);
    wait_until(rc + 3);

    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
